// File: rtl/cpu_wb_master.sv
// ----------------------------------------------------------------------------
// cpu_wb_master
//
// Wishbone B3 classic single-cycle master. It executes one CPU-bus request
// from the PC/UART packet decoder: the request is captured on cpu_start, one
// read or write cycle runs on the system bus, and cpu_active stays high until
// that cycle terminates. Slave retries are re-issued up to RETRY_MAX times.
// Errors, exhausted retries and (optionally) a watchdog timeout complete the
// request with bus_error set, so the PC link never hangs on a dead slave.
//
// Build option:
//   CPU_WB_TIMEOUT_EN  - when defined, a watchdog aborts a BUS phase that has
//                        seen no response for TIMEOUT cycles. When undefined,
//                        no counter is built and BUS waits indefinitely.
//
// Parameters:
//   dw        data width (selection stays 4 bits)
//   aw        address width
//   RETRY_MAX number of wb_rty_i re-issues before the request is failed
//   TIMEOUT   watchdog limit in clock cycles (used only with the macro)
//
// Ports:
//   wb_clk, wb_rst_n       clock (rising edge), async active-low reset
//   cpu_address/selection/write/data_wr, cpu_start   request from decoder
//   cpu_data_rd            read result, held until the next request completes
//   cpu_active             high while a request is in flight
//   bus_error              status of the last request (err/retry/timeout)
//   wb_adr_o .. wb_stb_o   registered Wishbone master outputs
//   wb_cti_o, wb_bte_o     tied to classic cycle / linear burst
//   wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i   slave responses
// ----------------------------------------------------------------------------
module cpu_wb_master #(
  parameter int dw        = 32,
  parameter int aw        = 32,
  parameter int RETRY_MAX = 4,
  parameter int TIMEOUT   = 1023
) (
  input  logic          wb_clk,
  input  logic          wb_rst_n,
  // CPU request side
  input  logic [aw-1:0] cpu_address,
  input  logic          cpu_start,
  input  logic [3:0]    cpu_selection,
  input  logic          cpu_write,
  input  logic [dw-1:0] cpu_data_wr,
  output logic [dw-1:0] cpu_data_rd,
  output logic          cpu_active,
  output logic          bus_error,
  // Wishbone master side
  output logic [aw-1:0] wb_adr_o,
  output logic [dw-1:0] wb_dat_o,
  output logic [3:0]    wb_sel_o,
  output logic          wb_we_o,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  output logic [2:0]    wb_cti_o,
  output logic [1:0]    wb_bte_o,
  input  logic [dw-1:0] wb_dat_i,
  input  logic          wb_ack_i,
  input  logic          wb_err_i,
  input  logic          wb_rty_i
);

  localparam int RtyW = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
  localparam logic [dw-1:0] ErrData = dw'(32'hDEAD_BEEF);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUS,
    ST_RETRY,
    ST_DONE
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [aw-1:0]   r_adr,   w_adr_nxt;
  logic [dw-1:0]   r_dat,   w_dat_nxt;
  logic [3:0]      r_sel,   w_sel_nxt;
  logic            r_we,    w_we_nxt;
  logic            r_cyc,   w_cyc_nxt;
  logic [dw-1:0]   r_rd,    w_rd_nxt;
  logic            r_active, w_active_nxt;
  logic            r_err,   w_err_nxt;
  logic [RtyW-1:0] r_rty,   w_rty_nxt;
  logic            w_tmo_hit;

`ifdef CPU_WB_TIMEOUT_EN
  // Watchdog: counts BUS cycles of the current phase, restarts in every
  // other state (so each retry gets a fresh budget) and holds at the limit.
  localparam int TmoW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [TmoW-1:0] r_tmo, w_tmo_nxt;

  assign w_tmo_hit = (r_tmo == TmoW'(TIMEOUT));

  always_comb begin
    w_tmo_nxt = '0;
    if (r_state == ST_BUS) begin
      w_tmo_nxt = w_tmo_hit ? r_tmo : r_tmo + 1'b1;
    end
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_tmo <= '0;
    end else begin
      r_tmo <= w_tmo_nxt;
    end
  end
`else
  // No watchdog: BUS waits for a slave response forever. The named-unused
  // net keeps the TIMEOUT parameter referenced in this build.
  logic w_unused_timeout;

  assign w_tmo_hit        = 1'b0;
  assign w_unused_timeout = (TIMEOUT != 0);
`endif

  // Next-state and next-register-value logic.
  // NOTE: every signal gets its default (hold) value first so that no path
  // through the case statement leaves one unassigned and infers a latch.
  always_comb begin
    w_state_nxt  = r_state;
    w_adr_nxt    = r_adr;
    w_dat_nxt    = r_dat;
    w_sel_nxt    = r_sel;
    w_we_nxt     = r_we;
    w_cyc_nxt    = r_cyc;
    w_rd_nxt     = r_rd;
    w_active_nxt = r_active;
    w_err_nxt    = r_err;
    w_rty_nxt    = r_rty;

    unique case (r_state)
      ST_IDLE: begin
        if (cpu_start) begin
          w_adr_nxt    = cpu_address;
          w_dat_nxt    = cpu_data_wr;
          w_sel_nxt    = cpu_selection;
          w_we_nxt     = cpu_write;
          w_cyc_nxt    = 1'b1;
          w_active_nxt = 1'b1;
          w_err_nxt    = 1'b0;
          w_state_nxt  = ST_BUS;
        end
      end

      ST_BUS: begin
        // Response priority: err > ack > rty > watchdog.
        if (wb_err_i) begin
          w_cyc_nxt   = 1'b0;
          w_err_nxt   = 1'b1;
          w_rd_nxt    = r_we ? r_rd : ErrData;
          w_state_nxt = ST_DONE;
        end else if (wb_ack_i) begin
          w_cyc_nxt   = 1'b0;
          w_rd_nxt    = r_we ? r_rd : wb_dat_i;
          w_state_nxt = ST_DONE;
        end else if (wb_rty_i) begin
          w_cyc_nxt = 1'b0;
          if (r_rty < RtyW'(RETRY_MAX)) begin
            w_rty_nxt   = r_rty + 1'b1;
            w_state_nxt = ST_RETRY;
          end else begin
            w_err_nxt   = 1'b1;
            w_rd_nxt    = r_we ? r_rd : ErrData;
            w_state_nxt = ST_DONE;
          end
        end else if (w_tmo_hit) begin
          w_cyc_nxt   = 1'b0;
          w_err_nxt   = 1'b1;
          w_rd_nxt    = r_we ? r_rd : ErrData;
          w_state_nxt = ST_DONE;
        end
      end

      // One idle cycle with cyc/stb low, then re-issue the latched request.
      ST_RETRY: begin
        w_cyc_nxt   = 1'b1;
        w_state_nxt = ST_BUS;
      end

      // cpu_active falls here, one cycle after the bus cycle ended, so the
      // decoder sees data and status already settled.
      ST_DONE: begin
        w_active_nxt = 1'b0;
        w_rty_nxt    = '0;
        w_state_nxt  = ST_IDLE;
      end

      default: begin
        w_cyc_nxt    = 1'b0;
        w_active_nxt = 1'b0;
        w_rty_nxt    = '0;
        w_state_nxt  = ST_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its next value from the same pre-edge snapshot.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_state  <= ST_IDLE;
      r_adr    <= '0;
      r_dat    <= '0;
      r_sel    <= '0;
      r_we     <= 1'b0;
      r_cyc    <= 1'b0;
      r_rd     <= '0;
      r_active <= 1'b0;
      r_err    <= 1'b0;
      r_rty    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_adr    <= w_adr_nxt;
      r_dat    <= w_dat_nxt;
      r_sel    <= w_sel_nxt;
      r_we     <= w_we_nxt;
      r_cyc    <= w_cyc_nxt;
      r_rd     <= w_rd_nxt;
      r_active <= w_active_nxt;
      r_err    <= w_err_nxt;
      r_rty    <= w_rty_nxt;
    end
  end

  assign cpu_data_rd = r_rd;
  assign cpu_active  = r_active;
  assign bus_error   = r_err;
  assign wb_adr_o    = r_adr;
  assign wb_dat_o    = r_dat;
  assign wb_sel_o    = r_sel;
  assign wb_we_o     = r_we;
  assign wb_cyc_o    = r_cyc;
  assign wb_stb_o    = r_cyc;   // single-cycle master: stb always tracks cyc
  assign wb_cti_o    = 3'b000;
  assign wb_bte_o    = 2'b00;

endmodule

// File: tb/tb_cpu_wb_master.sv
// ----------------------------------------------------------------------------
// tb_cpu_wb_master
//
// Self-checking bench for cpu_wb_master. Each request is given a script of
// slave responses (one entry per BUS cycle). A reference model walks that
// script with the protocol rules (priority, retry budget, watchdog) and
// predicts status, read data, number of BUS phases, BUS cycles and the
// length of cpu_active. Directed cases come first, then random requests,
// then a mid-cycle reset and recovery.
// ----------------------------------------------------------------------------
module tb_cpu_wb_master;

  localparam int RETRY_MAX = 4;
  localparam int TIMEOUT   = 16;

  localparam int R_NONE   = 0;
  localparam int R_ACK    = 1;
  localparam int R_ERR    = 2;
  localparam int R_RTY    = 3;
  localparam int R_ERRACK = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] cpu_address = '0;
  logic        cpu_start = 1'b0;
  logic [3:0]  cpu_selection = '0;
  logic        cpu_write = 1'b0;
  logic [31:0] cpu_data_wr = '0;
  logic [31:0] cpu_data_rd;
  logic        cpu_active;
  logic        bus_error;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic [2:0]  wb_cti_o;
  logic [1:0]  wb_bte_o;
  logic [31:0] wb_dat_i = '0;
  logic        wb_ack_i = 1'b0;
  logic        wb_err_i = 1'b0;
  logic        wb_rty_i = 1'b0;

  always #5 clk = ~clk;

  cpu_wb_master #(
    .dw(32), .aw(32), .RETRY_MAX(RETRY_MAX), .TIMEOUT(TIMEOUT)
  ) dut (
    .wb_clk(clk), .wb_rst_n(rst_n),
    .cpu_address(cpu_address), .cpu_start(cpu_start),
    .cpu_selection(cpu_selection), .cpu_write(cpu_write),
    .cpu_data_wr(cpu_data_wr), .cpu_data_rd(cpu_data_rd),
    .cpu_active(cpu_active), .bus_error(bus_error),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
    .wb_rty_i(wb_rty_i)
  );

  int total = 0;
  int bad   = 0;

  int          plan_q[$];
  int          exp_err, exp_phases, exp_bus, exp_active;
  logic [31:0] exp_rd = '0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_resp(input int r);
    wb_ack_i = (r == R_ACK) || (r == R_ERRACK);
    wb_err_i = (r == R_ERR) || (r == R_ERRACK);
    wb_rty_i = (r == R_RTY);
  endtask

  // Reference model: walk the response script one BUS cycle at a time.
  task automatic model();
    int retries = 0;
    int idle    = 0;
    int pc      = 0;
    bit done    = 1'b0;
    exp_err    = 0;
    exp_phases = 1;
    exp_bus    = 0;
    foreach (plan_q[i]) begin
      if (!done) begin
        exp_bus++;
        pc++;
        case (plan_q[i])
          R_ERR, R_ERRACK: begin exp_err = 1; done = 1'b1; end
          R_ACK:           done = 1'b1;
          R_RTY: begin
            if (retries < RETRY_MAX) begin
              retries++; idle++; exp_phases++; pc = 0;
            end else begin
              exp_err = 1; done = 1'b1;
            end
          end
          default: begin
`ifdef CPU_WB_TIMEOUT_EN
            if (pc == TIMEOUT + 1) begin exp_err = 1; done = 1'b1; end
`endif
          end
        endcase
      end
    end
    exp_active = exp_bus + idle + 1;
  endtask

  // Issue one request, play the response script, compare with the model.
  task automatic run_req(input string tag, input logic [31:0] addr,
                         input logic [3:0] sel, input logic we,
                         input logic [31:0] wdata, input logic [31:0] rdata);
    int n_act = 0;
    int n_bus = 0;
    int n_ph  = 0;
    logic prev = 1'b0;
    logic stable = 1'b1;
    model();
    if (!we) exp_rd = exp_err ? 32'hDEAD_BEEF : rdata;
    @(negedge clk);
    cpu_address = addr; cpu_selection = sel; cpu_write = we;
    cpu_data_wr = wdata; wb_dat_i = rdata; cpu_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cpu_start = 1'b0;
    check({tag, " cyc_up"}, {31'd0, wb_cyc_o}, 32'd1);
    check({tag, " active_up"}, {31'd0, cpu_active}, 32'd1);
    check({tag, " we"}, {31'd0, wb_we_o}, {31'd0, we});
    for (int k = 0; k < 400; k++) begin
      if (!cpu_active) break;
      n_act++;
      if (wb_cyc_o && wb_stb_o) begin
        n_bus++;
        if (!prev) n_ph++;
        if (wb_adr_o !== addr || wb_dat_o !== wdata || wb_sel_o !== sel ||
            wb_we_o !== we) stable = 1'b0;
        drive_resp(plan_q.size() > 0 ? plan_q.pop_front() : R_NONE);
      end else begin
        drive_resp(R_NONE);
      end
      prev = wb_cyc_o;
      @(negedge clk);
    end
    drive_resp(R_NONE);
    check({tag, " finished"}, {31'd0, cpu_active}, 32'd0);
    check({tag, " cyc_down"}, {31'd0, wb_cyc_o}, 32'd0);
    check({tag, " bus_error"}, {31'd0, bus_error}, exp_err);
    check({tag, " data_rd"}, cpu_data_rd, exp_rd);
    check({tag, " phases"}, n_ph, exp_phases);
    check({tag, " bus_cycles"}, n_bus, exp_bus);
    check({tag, " active_cycles"}, n_act, exp_active);
    check({tag, " stable"}, {31'd0, stable}, 32'd1);
    plan_q.delete();
  endtask

  initial begin
    int stall_cycles;

    // Reset state.
    #12;
    check("rst cyc", {31'd0, wb_cyc_o}, 32'd0);
    check("rst stb", {31'd0, wb_stb_o}, 32'd0);
    check("rst active", {31'd0, cpu_active}, 32'd0);
    check("rst err", {31'd0, bus_error}, 32'd0);
    check("rst data_rd", cpu_data_rd, 32'd0);
    check("rst adr", wb_adr_o, 32'd0);
    check("rst cti_bte", {27'd0, wb_cti_o, wb_bte_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Write with three wait states.
    plan_q = '{R_NONE, R_NONE, R_NONE, R_ACK};
    run_req("wr_wait3", 32'h4000_0010, 4'hF, 1'b1, 32'h1234_5678, 32'h0);

    // Zero-wait read, issued back-to-back after the write.
    plan_q = '{R_ACK};
    run_req("rd_zero", 32'h4000_0000, 4'hF, 1'b0, 32'h0, 32'hCAFE_F00D);
    check("rd_zero value", cpu_data_rd, 32'hCAFE_F00D);

    // Retry exhaustion on a read.
    plan_q = '{R_RTY, R_RTY, R_RTY, R_RTY, R_RTY};
    run_req("rty_exhaust", 32'h4000_0020, 4'h3, 1'b0, 32'h0, 32'h1111_2222);
    check("rty_exhaust value", cpu_data_rd, 32'hDEAD_BEEF);

    // Retries that eventually succeed.
    plan_q = '{R_RTY, R_NONE, R_RTY, R_ACK};
    run_req("rty_ok", 32'h4000_0024, 4'hC, 1'b0, 32'h0, 32'h5555_AAAA);

    // err and ack together: err wins.
    plan_q = '{R_NONE, R_ERRACK};
    run_req("err_ack", 32'h4000_0030, 4'h1, 1'b0, 32'h0, 32'h7777_8888);

    // Error on a write leaves read data untouched.
    plan_q = '{R_ERR};
    run_req("wr_err", 32'h4000_0034, 4'hF, 1'b1, 32'h9ABC_DEF0, 32'h0);

`ifdef CPU_WB_TIMEOUT_EN
    // Slave never responds: the watchdog ends the request.
    for (int i = 0; i < 24; i++) plan_q.push_back(R_NONE);
    run_req("timeout", 32'h4000_0040, 4'hF, 1'b0, 32'h0, 32'h0BAD_0BAD);
    stall_cycles = 5;
`else
    stall_cycles = 2000;
`endif

    // Randomized requests.
    for (int n = 0; n < 24; n++) begin
      int nr;
      int fin;
      nr = $urandom_range(0, RETRY_MAX + 1);
      for (int r = 0; r < nr; r++) begin
        repeat ($urandom_range(0, 2)) plan_q.push_back(R_NONE);
        plan_q.push_back(R_RTY);
      end
      repeat ($urandom_range(0, 2)) plan_q.push_back(R_NONE);
      fin = $urandom_range(0, 9);
      plan_q.push_back(fin < 6 ? R_ACK : (fin < 8 ? R_ERR : R_ERRACK));
      run_req($sformatf("rand%0d", n), $urandom, 4'($urandom_range(0, 15)),
              1'($urandom_range(0, 1)), $urandom, $urandom);
    end

    // Unresponsive slave, then reset mid-BUS.
    @(negedge clk);
    cpu_address = 32'h4000_0050; cpu_write = 1'b0; cpu_selection = 4'hF;
    cpu_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cpu_start = 1'b0;
    repeat (stall_cycles) @(posedge clk);
    @(negedge clk);
    check("stall cyc_high", {31'd0, wb_cyc_o}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("async cyc", {31'd0, wb_cyc_o}, 32'd0);
    check("async stb", {31'd0, wb_stb_o}, 32'd0);
    check("async active", {31'd0, cpu_active}, 32'd0);
    exp_rd = 32'd0;
    check("async data_rd", cpu_data_rd, exp_rd);
    @(negedge clk);
    rst_n = 1'b1;

    // Normal operation after reset.
    plan_q = '{R_NONE, R_ACK};
    run_req("post_rst", 32'h4000_0060, 4'h6, 1'b0, 32'h0, 32'h0123_4567);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
